aqfp_c17_phase_pipe: RTL and testbench

//  Cycle-accurate, parametrised model of the c17 benchmark in an NPH-phase AQFP clocking scheme

---
 rtl/aqfp_c17_phase_pipe.sv | 89 ++++++++
 tb/tb_aqfp_c17_phase_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/aqfp_c17_phase_pipe.sv
// Phase-accurate golden model of the c17 benchmark on an NPH-phase AQFP clock.
// One wave is accepted per full phase cycle, and its result emerges LAT_PH ticks later; the pipeline never stalls.
module aqfp_c17_phase_pipe #(
    parameter int LANES  = 1,
    parameter int NPH    = 8,
    parameter int LAT_PH = 9,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5*LANES-1:0]   in_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*LANES-1:0]   out_vec,
    output logic [NPH-1:0]       phase_oh,
    output logic                 overrun,
    output logic [CNT_W-1:0]     wave_cnt
);

    localparam int PH_W = (NPH > 2) ? $clog2(NPH) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(NPH - 1);

    logic [PH_W-1:0]    ph;
    logic [LAT_PH-1:0]  pipe_vld;
    logic [2*LANES-1:0] pipe_data [LAT_PH];
    logic [2*LANES-1:0] result;
    logic               accept;

    assign in_ready  = en & (ph == '0);
    assign accept    = in_valid & in_ready;
    assign out_valid = pipe_vld[LAT_PH-1];
    assign out_vec   = pipe_vld[LAT_PH-1] ? pipe_data[LAT_PH-1] : '0;

    // Lane fields are {N7,N6,N3,N2,N1}; results are packed as {N23,N22}.
    always_comb begin
        result = '0;
        for (int i = 0; i < LANES; i++) begin
            result[2*i]   = (in_vec[5*i] & in_vec[5*i+2])
                          | (in_vec[5*i+1] & ~(in_vec[5*i+2] & in_vec[5*i+3]));
            result[2*i+1] = ~(in_vec[5*i+2] & in_vec[5*i+3])
                          & (in_vec[5*i+1] | in_vec[5*i+4]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph       <= '0;
            phase_oh <= NPH'(1);
        end else if (en) begin
            ph       <= (ph == PH_LAST) ? '0 : ph + 1'b1;
            phase_oh <= {phase_oh[NPH-2:0], phase_oh[NPH-1]};
        end
    end

    // Bubbles enter with zero data so an idle slot can never leak a stale result.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < LAT_PH; i++) begin
                pipe_data[i] <= '0;
            end
        end else if (en) begin
            pipe_vld[0]  <= accept;
            pipe_data[0] <= accept ? result : '0;
            for (int i = 1; i < LAT_PH; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    // The output wave leaves on every enabled edge whether or not the sink took it.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun  <= 1'b0;
            wave_cnt <= '0;
        end else if (en && out_valid) begin
            if (!out_ready) begin
                overrun <= 1'b1;
            end else if (wave_cnt != '1) begin
                wave_cnt <= wave_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aqfp_c17_phase_pipe.sv
// Scoreboard bench for aqfp_c17_phase_pipe: default build plus a 4-lane, 4-phase build.
// Accepted waves are queued with their due tick and compared against the DUT outputs on every falling edge.
module tb_aqfp_c17_phase_pipe;

    typedef struct {
        logic [7:0] data;
        int         due;
    } wave_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default instance signals (NPH=8, LAT_PH=9)
    logic        a_rst = 1'b1, a_en = 1'b1, a_in_valid = 1'b0, a_out_ready = 1'b1;
    logic [4:0]  a_in_vec = '0;
    logic        a_in_ready, a_out_valid, a_overrun;
    logic [1:0]  a_out_vec;
    logic [7:0]  a_phase_oh;
    logic [15:0] a_wave_cnt;

    // Wide instance signals (LANES=4, NPH=4, LAT_PH=6, CNT_W=2)
    logic        b_rst = 1'b1, b_en = 1'b1, b_in_valid = 1'b0, b_out_ready = 1'b1;
    logic [19:0] b_in_vec = '0;
    logic        b_in_ready, b_out_valid, b_overrun;
    logic [7:0]  b_out_vec;
    logic [3:0]  b_phase_oh;
    logic [1:0]  b_wave_cnt;

    aqfp_c17_phase_pipe dut_a (
        .clk(clk), .rst(a_rst), .en(a_en),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_vec(a_in_vec),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_vec(a_out_vec),
        .phase_oh(a_phase_oh), .overrun(a_overrun), .wave_cnt(a_wave_cnt)
    );

    aqfp_c17_phase_pipe #(.LANES(4), .NPH(4), .LAT_PH(6), .CNT_W(2)) dut_b (
        .clk(clk), .rst(b_rst), .en(b_en),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(b_in_vec),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_vec(b_out_vec),
        .phase_oh(b_phase_oh), .overrun(b_overrun), .wave_cnt(b_wave_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] c17(input logic [4:0] v);
        logic n1, n2, n3, n6, n7;
        {n7, n6, n3, n2, n1} = v;
        return {~(n3 & n6) & (n2 | n7), (n1 & n3) | (n2 & ~(n3 & n6))};
    endfunction

    // Reference model state, advanced on the rising edge from bench-side inputs only
    wave_t qa[$];
    wave_t qb[$];
    int a_ph = 0, a_tick = 0, a_cnt = 0;
    int b_ph = 0, b_tick = 0, b_cnt = 0;
    logic a_ovr = 1'b0, b_ovr = 1'b0;

    always @(posedge clk) begin
        if (a_rst) begin
            qa.delete();
            a_ph = 0; a_ovr = 1'b0; a_cnt = 0;
        end else if (a_en) begin
            if (qa.size() > 0 && qa[0].due == a_tick) begin
                if (a_out_ready) a_cnt = (a_cnt == 65535) ? a_cnt : a_cnt + 1;
                else a_ovr = 1'b1;
                void'(qa.pop_front());
            end
            if (a_in_valid && a_ph == 0) qa.push_back('{data: {6'd0, c17(a_in_vec)}, due: a_tick + 9});
            a_ph = (a_ph + 1) % 8;
            a_tick++;
        end
    end

    always @(posedge clk) begin
        logic [7:0] exp_data;
        if (b_rst) begin
            qb.delete();
            b_ph = 0; b_ovr = 1'b0; b_cnt = 0;
        end else if (b_en) begin
            if (qb.size() > 0 && qb[0].due == b_tick) begin
                if (b_out_ready) b_cnt = (b_cnt == 3) ? b_cnt : b_cnt + 1;
                else b_ovr = 1'b1;
                void'(qb.pop_front());
            end
            if (b_in_valid && b_ph == 0) begin
                for (int l = 0; l < 4; l++) exp_data[2*l +: 2] = c17(b_in_vec[5*l +: 5]);
                qb.push_back('{data: exp_data, due: b_tick + 6});
            end
            b_ph = (b_ph + 1) % 4;
            b_tick++;
        end
    end

    // Compare every visible output against the model once per cycle
    always @(negedge clk) begin
        logic ev;
        ev = (qa.size() > 0) && (qa[0].due == a_tick);
        checkOutput("a_out_valid", 32'(a_out_valid), 32'(ev));
        checkOutput("a_out_vec", 32'(a_out_vec), ev ? 32'(qa[0].data) : 32'd0);
        checkOutput("a_phase_oh", 32'(a_phase_oh), 32'd1 << a_ph);
        checkOutput("a_in_ready", 32'(a_in_ready), 32'(a_en && a_ph == 0));
        checkOutput("a_overrun", 32'(a_overrun), 32'(a_ovr));
        checkOutput("a_wave_cnt", 32'(a_wave_cnt), 32'(a_cnt));
        if (a_out_valid) checkOutput("a_valid_phase", 32'(a_phase_oh), 32'd2);

        ev = (qb.size() > 0) && (qb[0].due == b_tick);
        checkOutput("b_out_valid", 32'(b_out_valid), 32'(ev));
        checkOutput("b_out_vec", 32'(b_out_vec), ev ? 32'(qb[0].data) : 32'd0);
        checkOutput("b_phase_oh", 32'(b_phase_oh), 32'd1 << b_ph);
        checkOutput("b_in_ready", 32'(b_in_ready), 32'(b_en && b_ph == 0));
        checkOutput("b_overrun", 32'(b_overrun), 32'(b_ovr));
        checkOutput("b_wave_cnt", 32'(b_wave_cnt), 32'(b_cnt));
        if (b_out_valid) checkOutput("b_valid_phase", 32'(b_phase_oh), 32'd4);
    end

    task automatic applyStimulus(input logic v, input logic [4:0] vec, input logic rdy, input logic e);
        a_in_valid  = v;
        a_in_vec    = vec;
        a_out_ready = rdy;
        a_en        = e;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulusWide(input logic v, input logic [19:0] vec);
        b_in_valid = v;
        b_in_vec   = vec;
        @(posedge clk);
        #1;
    endtask

    task automatic idleA(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, rdy, 1'b1);
    endtask

    task automatic alignA();
        for (int i = 0; i < 8 && a_ph != 0; i++) applyStimulus(1'b0, 5'd0, 1'b1, 1'b1);
        checkOutput("a_align", 32'(a_ph), 32'd0);
    endtask

    initial begin
        logic [19:0] wide;

        // 1: single wave with every input high
        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b0;
        alignA();
        applyStimulus(1'b1, 5'b11111, 1'b1, 1'b1);
        idleA(12, 1'b1);
        checkOutput("t1_wave_cnt", 32'(a_wave_cnt), 32'd1);

        // 2: three back-to-back slots
        alignA();
        applyStimulus(1'b1, 5'b00000, 1'b1, 1'b1);
        idleA(7, 1'b1);
        applyStimulus(1'b1, 5'b00010, 1'b1, 1'b1);
        idleA(7, 1'b1);
        applyStimulus(1'b1, 5'b10000, 1'b1, 1'b1);
        idleA(14, 1'b1);

        // 3: in_valid raised at ph==3 is held until the next ph==0 slot
        alignA();
        idleA(3, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 5'b01101, 1'b1, 1'b1);
        idleA(18, 1'b1);
        checkOutput("t3_wave_cnt", 32'(a_wave_cnt), 32'd5);

        // 4: sink refuses the first of two waves
        alignA();
        applyStimulus(1'b1, 5'b00111, 1'b1, 1'b1);
        idleA(7, 1'b1);
        applyStimulus(1'b1, 5'b01010, 1'b1, 1'b1);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
        idleA(12, 1'b1);
        checkOutput("t4_overrun", 32'(a_overrun), 32'd1);
        checkOutput("t4_wave_cnt", 32'(a_wave_cnt), 32'd6);

        // 5: enable dropped for five cycles mid-flight
        alignA();
        applyStimulus(1'b1, 5'b11010, 1'b1, 1'b1);
        idleA(3, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 5'd0, 1'b1, 1'b0);
        idleA(12, 1'b1);
        checkOutput("t5_wave_cnt", 32'(a_wave_cnt), 32'd7);

        // 5b: reset with two waves in flight
        alignA();
        applyStimulus(1'b1, 5'b00010, 1'b1, 1'b1);
        idleA(7, 1'b1);
        applyStimulus(1'b1, 5'b10000, 1'b1, 1'b1);
        idleA(2, 1'b1);
        a_rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 1'b1, 1'b1);
        a_rst = 1'b0;
        idleA(20, 1'b1);
        checkOutput("t5_rst_wave_cnt", 32'(a_wave_cnt), 32'd0);
        checkOutput("t5_rst_overrun", 32'(a_overrun), 32'd0);
        checkOutput("a_drained", 32'(qa.size()), 32'd0);

        // 6: four-lane build sweeps all 32 input patterns
        b_rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4 && b_ph != 0; i++) applyStimulusWide(1'b0, 20'd0);
            checkOutput("b_align", 32'(b_ph), 32'd0);
            for (int l = 0; l < 4; l++) wide[5*l +: 5] = 5'(4*k + l);
            applyStimulusWide(1'b1, wide);
        end
        for (int i = 0; i < 12; i++) applyStimulusWide(1'b0, 20'd0);
        checkOutput("t6_wave_cnt_sat", 32'(b_wave_cnt), 32'd3);
        checkOutput("b_drained", 32'(qb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
